// File: rtl/debouncer_multi.sv
// N-channel switch debouncer: 2-flop synchroniser, consecutive-disagreement filter, press/release pulses.
// Optional long-press HOLD flag per channel, compiled in with `DEBOUNCER_HOLD_EN.
module debouncer_multi #(
  parameter int N           = 4,
  parameter int SETTLE      = 50_000,
  parameter int HOLD_CYCLES = 50_000_000
) (
  input  logic         CLK50M,
  input  logic         RST,
  input  logic [N-1:0] A_noisy,
  output logic [N-1:0] A,
  output logic [N-1:0] RISE,
  output logic [N-1:0] FALL,
  output logic [N-1:0] HOLD
);

  localparam int            CW      = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(SETTLE - 1);

  logic [N-1:0]  r_s1;
  logic [N-1:0]  r_s;
  logic [N-1:0]  r_a;
  logic [N-1:0]  r_rise;
  logic [N-1:0]  r_fall;
  logic [CW-1:0] r_cnt [N];

  logic [N-1:0]  w_flip;
  logic [N-1:0]  w_a_next;

  // A channel flips only after SETTLE consecutive disagreeing samples.
  always_comb begin
    w_flip = '0;
    for (int i = 0; i < N; i++) begin
      w_flip[i] = (r_s[i] != r_a[i]) && (r_cnt[i] == CNT_MAX);
    end
    w_a_next = r_a ^ w_flip;
  end

  always_ff @(posedge CLK50M or posedge RST) begin
    if (RST) begin
      r_s1   <= '0;
      r_s    <= '0;
      r_a    <= '0;
      r_rise <= '0;
      r_fall <= '0;
      for (int i = 0; i < N; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_s1   <= A_noisy;
      r_s    <= r_s1;
      r_a    <= w_a_next;
      r_rise <= w_flip & ~r_a;
      r_fall <= w_flip & r_a;
      for (int i = 0; i < N; i++) begin
        if ((r_s[i] == r_a[i]) || w_flip[i]) begin
          r_cnt[i] <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign A    = r_a;
  assign RISE = r_rise;
  assign FALL = r_fall;

`ifdef DEBOUNCER_HOLD_EN
  localparam int            HW       = $clog2(HOLD_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES);

  logic [HW-1:0] r_hold [N];

  // Cleared on the falling edge itself so HOLD drops together with A.
  always_ff @(posedge CLK50M or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < N; i++) begin
        r_hold[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (!w_a_next[i]) begin
          r_hold[i] <= '0;
        end else if (r_a[i] && (r_hold[i] != HOLD_MAX)) begin
          r_hold[i] <= r_hold[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    HOLD = '0;
    for (int i = 0; i < N; i++) begin
      HOLD[i] = (r_hold[i] == HOLD_MAX);
    end
  end
`else
  assign HOLD = '0;
`endif

endmodule

// File: tb/tb_debouncer_multi.sv
// Self-checking bench for debouncer_multi (N=4, SETTLE=8, HOLD_CYCLES=20).
// HOLD expectations follow whether DEBOUNCER_HOLD_EN is defined for the build.
module tb_debouncer_multi;

  logic       CLK50M;
  logic       RST;
  logic [3:0] A_noisy;
  logic [3:0] A, RISE, FALL, HOLD;

  int n_pass  = 0;
  int n_total = 0;

`ifdef DEBOUNCER_HOLD_EN
  localparam bit HOLD_ON = 1'b1;
`else
  localparam bit HOLD_ON = 1'b0;
`endif

  debouncer_multi #(.N(4), .SETTLE(8), .HOLD_CYCLES(20)) dut (
    .CLK50M (CLK50M),
    .RST    (RST),
    .A_noisy(A_noisy),
    .A      (A),
    .RISE   (RISE),
    .FALL   (FALL),
    .HOLD   (HOLD)
  );

  initial CLK50M = 1'b0;
  always #5 CLK50M = ~CLK50M;

  typedef struct {
    logic [3:0] ain;
    int         n;
    logic [3:0] a;
    logic [3:0] rise;
    logic [3:0] fall;
    logic [3:0] hold;
  } vec_t;

  vec_t tbl [17];

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge CLK50M);
      #1;
    end
  endtask

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic chk_all(input string name, input logic [3:0] ea, input logic [3:0] er,
                         input logic [3:0] ef, input logic [3:0] eh);
    chk({name, ".A"},    A,    ea);
    chk({name, ".RISE"}, RISE, er);
    chk({name, ".FALL"}, FALL, ef);
    chk({name, ".HOLD"}, HOLD, HOLD_ON ? eh : 4'h0);
  endtask

  bit bp [14];
  int rise_cnt;

  initial begin
    // ain, ticks, A, RISE, FALL, HOLD (sampled after the last tick)
    tbl[0]  = '{4'h1, 9,  4'h0, 4'h0, 4'h0, 4'h0};
    tbl[1]  = '{4'h1, 1,  4'h1, 4'h1, 4'h0, 4'h0};
    tbl[2]  = '{4'h1, 1,  4'h1, 4'h0, 4'h0, 4'h0};
    tbl[3]  = '{4'h1, 18, 4'h1, 4'h0, 4'h0, 4'h0};
    tbl[4]  = '{4'h1, 1,  4'h1, 4'h0, 4'h0, 4'h1};
    tbl[5]  = '{4'h0, 9,  4'h1, 4'h0, 4'h0, 4'h1};
    tbl[6]  = '{4'h0, 1,  4'h0, 4'h0, 4'h1, 4'h0};
    tbl[7]  = '{4'h0, 1,  4'h0, 4'h0, 4'h0, 4'h0};
    tbl[8]  = '{4'hF, 9,  4'h0, 4'h0, 4'h0, 4'h0};
    tbl[9]  = '{4'hF, 1,  4'hF, 4'hF, 4'h0, 4'h0};
    tbl[10] = '{4'hF, 1,  4'hF, 4'h0, 4'h0, 4'h0};
    tbl[11] = '{4'h6, 9,  4'hF, 4'h0, 4'h0, 4'h0};
    tbl[12] = '{4'h6, 1,  4'h6, 4'h0, 4'h9, 4'h0};
    tbl[13] = '{4'h6, 1,  4'h6, 4'h0, 4'h0, 4'h0};
    tbl[14] = '{4'h6, 8,  4'h6, 4'h0, 4'h0, 4'h6};
    tbl[15] = '{4'h0, 10, 4'h0, 4'h0, 4'h6, 4'h0};
    tbl[16] = '{4'h0, 1,  4'h0, 4'h0, 4'h0, 4'h0};

    // high 1, low 1, high 3, low 1, high 7, low 1
    bp = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    A_noisy = 4'h0;
    RST     = 1'b1;
    tick(3);
    RST = 1'b0;
    chk_all("reset", 4'h0, 4'h0, 4'h0, 4'h0);

    for (int v = 0; v < 17; v++) begin
      A_noisy = tbl[v].ain;
      tick(tbl[v].n);
      chk_all($sformatf("vec%0d", v), tbl[v].a, tbl[v].rise, tbl[v].fall, tbl[v].hold);
    end

    // Bounce rejection on channel 1: longest high run is SETTLE-1 samples.
    for (int j = 0; j < 14; j++) begin
      A_noisy = {2'b00, bp[j], 1'b0};
      tick(1);
      chk("bounce1", {1'b0, A[1], RISE[1], FALL[1]}, 4'h0);
    end
    A_noisy = 4'h0;
    for (int j = 0; j < 12; j++) begin
      tick(1);
      chk("bounce1_low", {1'b0, A[1], RISE[1], FALL[1]}, 4'h0);
    end

    // Bounce then settle on channel 2.
    rise_cnt = 0;
    for (int j = 0; j < 14; j++) begin
      A_noisy = {1'b0, bp[j], 2'b00};
      tick(1);
      if (RISE[2]) rise_cnt++;
      chk("settle2_bounce", {3'b000, A[2]}, 4'h0);
    end
    A_noisy = 4'h4;
    tick(9);
    chk("settle2_pre", {3'b000, A[2]}, 4'h0);
    tick(1);
    chk("settle2_edge", {2'b00, A[2], RISE[2]}, 4'h3);
    for (int j = 0; j < 10; j++) begin
      if (RISE[2]) rise_cnt++;
      tick(1);
    end
    chk("settle2_rise_count", 4'(rise_cnt), 4'h1);
    A_noisy = 4'h0;
    tick(14);
    chk("settle2_release", A, 4'h0);

    // Reset mid-count: channel 3 already qualified, channel 0 at cnt=5.
    A_noisy = 4'h8;
    tick(12);
    chk("rst_pre_a", A, 4'h8);
    A_noisy = 4'h9;
    tick(7);
    #2 RST = 1'b1;
    #1;
    chk_all("rst_async", 4'h0, 4'h0, 4'h0, 4'h0);
    @(posedge CLK50M);
    #1 RST = 1'b0;
    tick(9);
    chk_all("rst_requal_pre", 4'h0, 4'h0, 4'h0, 4'h0);
    tick(1);
    chk_all("rst_requal_edge", 4'h9, 4'h9, 4'h0, 4'h0);
    tick(1);
    chk_all("rst_requal_post", 4'h9, 4'h0, 4'h0, 4'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/debouncer_multi.md
# debouncer_multi

Parametrised multi-channel switch debouncer for the vending FSM front panel. Each of `N` asynchronous, bouncy inputs is synchronised, then filtered with a per-channel consecutive-agreement counter. The block emits a clean level per channel, one-cycle press/release pulses and, optionally, a long-press hold flag. It sits between the board pins and the vending FSM and replaces per-button single-channel debouncing.

## Interface
- `N`, default 4: number of independent channels.
- `SETTLE`, default 50_000: consecutive cycles the synchronised input must disagree with the output before the output flips; 1 ms at 50 MHz; legal values are ≥1.
- `HOLD_CYCLES`, default 50_000_000: cycles of continuous debounced-high before `HOLD` asserts; 1 s at 50 MHz; legal values are ≥1; used only with `DEBOUNCER_HOLD_EN`.
- `CLK50M`, in, 1: single clock; all state updates on its rising edge.
- `RST`, in, 1: reset, asynchronous and active-high.
- `A_noisy`, in, N: raw asynchronous switch inputs; bit i is channel i.
- `A`, out, N: debounced level per channel.
- `RISE`, out, N: one-cycle pulse on the edge where `A[i]` goes 0→1.
- `FALL`, out, N: one-cycle pulse on the edge where `A[i]` goes 1→0.
- `HOLD`, out, N: long-press flag per channel; constant 0 when the feature is compiled out.

## Operation
- Each channel has a 2-flop synchroniser: `A_noisy[i]` → `s1[i]` → `s[i]`. No logic sits between the two flops.
- Each channel has a counter `cnt[i]`, width max(1, $clog2(SETTLE)).
- Per-channel update on each edge:
  - If `s[i] == A[i]`: `cnt[i] <= 0`.
  - Else if `cnt[i] == SETTLE-1`: `A[i] <= s[i]` and `cnt[i] <= 0`.
  - Else: `cnt[i] <= cnt[i]+1`.
- A single agreeing sample restarts the count. Any bounce shorter than `SETTLE` cycles never reaches `A`.
- `RISE[i]` and `FALL[i]` are registered. They are high for exactly the one cycle following the edge on which `A[i]` changed, and are never high together.
- Channels are fully independent. Simultaneous transitions on any subset of channels are processed in parallel, with no arbitration and no cross-channel influence.
- The counter never exceeds `SETTLE-1`, so there is no wrap-around.
- Reset clears all state. `s1`, `s`, `cnt`, `A`, `RISE`, `FALL`, `HOLD` and the hold counters are all 0.
- Reset asserted mid-count discards the count. After release, a channel whose input is held high re-qualifies with full latency.
- After reset release, a pin already high produces a `RISE` pulse once qualified. This is intended: the FSM sees the button as a press.

## Timing
- Input stable from the cycle before edge k: `s1` updates at edge k, `s` at edge k+1.
- `A` changes at edge k+1+SETTLE. Total latency is SETTLE+2 edges from the first edge sampling the new value.
- `RISE`/`FALL` go high at the same edge as `A` and drop at the next edge.
- `HOLD` asserts at the edge where the hold counter reaches `HOLD_CYCLES`, counting edges with `A[i]`=1 that start on the edge after `A` rose.
- `HOLD` deasserts at the same edge `A[i]` falls.
- The reset path is asynchronous; reset release must be synchronous to `CLK50M`, which the board-level reset synchroniser provides.

## Configuration
- Macro: `DEBOUNCER_HOLD_EN`.
- Defined:
  - Each channel gets a saturating hold counter of width $clog2(HOLD_CYCLES+1).
  - The counter clears while `A[i]`=0, increments while `A[i]`=1, and saturates at `HOLD_CYCLES`.
  - `HOLD[i]` = (hold counter == `HOLD_CYCLES`).
- Undefined:
  - No hold counters are instantiated.
  - `HOLD` is tied to 0.
  - Port list is unchanged so that instantiations are identical in both builds.

## Test plan
All scenarios use N=4, SETTLE=8, HOLD_CYCLES=20, with `DEBOUNCER_HOLD_EN` defined unless noted.
- **Clean press:** `A_noisy[0]` 0→1 held 30 cycles → `A[0]` rises exactly 10 edges after the first sampling edge; `RISE[0]` is high for 1 cycle; other channels stay at 0.
- **Bounce rejection:** `A_noisy[1]` toggles with high pulses of 1, 3, 7 cycles separated by 1-cycle lows, then held low → `A[1]`, `RISE[1]` and `FALL[1]` stay at 0 throughout.
- **Bounce then settle:** `A_noisy[2]` bounces as above, then is held high 20 cycles → `A[2]` rises 10 edges after the last 0→1 transition is sampled; exactly one `RISE[2]` pulse.
- **Simultaneous channels:** all four inputs go high on the same cycle → `A` goes to 4'hF on a single edge and `RISE` = 4'hF for one cycle. Releasing channels 0 and 3 together → `FALL` = 4'h9 for one cycle.
- **Hold:** `A_noisy[3]` held high 40 cycles, then released:
  - `HOLD[3]` asserts 20 edges after `A[3]` rose.
  - `HOLD[3]` clears on the same edge `A[3]` falls.
  - With the macro undefined, `HOLD` stays at 4'h0.
- **Reset mid-count:** `RST` is pulsed asynchronously while `cnt[0]`=5 → all outputs go to 0 immediately. With the input still high after release, `A[0]` rises SETTLE+2 edges after release and `RISE[0]` pulses once.
